// File: rtl/spi_tx_feeder.sv
// Byte FIFO plus sequencer feeding an SPI byte transmitter: holds tx_en across
// back-to-back bytes, inserts an inter-frame gap and watches for a stalled transmitter.
module spi_tx_feeder #(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     I_wr_en,
  input  logic [7:0]               I_wr_data,
  input  logic                     I_wr_last,
  input  logic                     I_flush,
  input  logic                     I_clr_err,
  output logic                     O_full,
  output logic [$clog2(DEPTH):0]   O_level,
  output logic                     O_tx_en,
  output logic [7:0]               O_data_out,
  input  logic                     I_tx_done,
  output logic                     O_busy,
  output logic                     O_frame_done,
  output logic                     O_err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_GAP, ST_ERR} state_e;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            full_q, full_d;
  state_e          state_q, state_d;
  logic            tx_en_q, tx_en_d;
  logic [7:0]      data_q, data_d;
  logic            last_q, last_d;
  logic            frame_done_q, frame_done_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic [WW-1:0]   wd_cnt_q, wd_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;

  logic            push, pop, load_head, fifo_empty;
  entry_t          head;

  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (level_q == '0);
  assign push       = I_wr_en & ~full_q & ~I_flush;

  // NOTE: every variable gets a default before any branch so no path leaves one
  // unassigned; without that, always_comb would infer a latch.
  always_comb begin
    state_d      = state_q;
    tx_en_d      = tx_en_q;
    data_d       = data_q;
    last_d       = last_q;
    frame_done_d = 1'b0;
    err_d        = err_q & ~I_clr_err;
    wd_cnt_d     = wd_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    load_head    = 1'b0;

    if (I_flush) begin
      state_d = ST_IDLE;
      tx_en_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
        ST_LOAD: load_head = 1'b1;
        ST_SEND: begin
          if (I_tx_done) begin
            if (last_q) begin
              tx_en_d      = 1'b0;
              frame_done_d = 1'b1;
              gap_cnt_d    = GW'(GAP_CYCLES - 1);
              state_d      = ST_GAP;
            end else if (!fifo_empty) begin
              load_head = 1'b1;
            end else begin
              tx_en_d = 1'b0;
              state_d = ST_IDLE;
            end
          end else if (wd_cnt_q == WW'(TIMEOUT - 1)) begin
            tx_en_d = 1'b0;
            err_d   = 1'b1;
            state_d = ST_ERR;
          end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
          end
        end
        // The final gap cycle doubles as the load slot, so tx_en is low for
        // exactly GAP_CYCLES cycles when the next frame is already queued.
        ST_GAP: begin
          if (gap_cnt_q == '0) begin
            if (!fifo_empty) load_head = 1'b1;
            else             state_d   = ST_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q - 1'b1;
          end
        end
        ST_ERR:  if (I_clr_err) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    if (load_head) begin
      data_d   = head.data;
      last_d   = head.last;
      tx_en_d  = 1'b1;
      wd_cnt_d = '0;
      state_d  = ST_SEND;
    end

    pop    = load_head;
    busy_d = (state_d != ST_IDLE);
  end

  always_comb begin
    if (I_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      level_d  = level_q + LW'(push) - LW'(pop);
    end
    full_d = (level_d == LW'(DEPTH));
  end

  // NOTE: the storage array has no reset; the pointers and level define which
  // entries are valid, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{last: I_wr_last, data: I_wr_data};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before this edge regardless of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      full_q       <= 1'b0;
      tx_en_q      <= 1'b0;
      data_q       <= '0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      wd_cnt_q     <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      full_q       <= full_d;
      tx_en_q      <= tx_en_d;
      data_q       <= data_d;
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      wd_cnt_q     <= wd_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign O_full        = full_q;
  assign O_level       = level_q;
  assign O_tx_en       = tx_en_q;
  assign O_data_out    = data_q;
  assign O_busy        = busy_q;
  assign O_frame_done  = frame_done_q;
  assign O_err_timeout = err_q;

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Self-checking bench for spi_tx_feeder: a byte-level transmitter model plus
// frame-level expectations (bytes, tx_en run lengths, gaps, pulses).
module tb_spi_tx_feeder;

  localparam int DEPTH    = 16;
  localparam int GAP      = 4;
  localparam int TIMEOUT  = 64;
  localparam int BYTE_CYC = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       I_wr_en = 1'b0;
  logic [7:0] I_wr_data = 8'h00;
  logic       I_wr_last = 1'b0;
  logic       I_flush = 1'b0;
  logic       I_clr_err = 1'b0;
  logic       I_tx_done = 1'b0;
  logic       O_full, O_tx_en, O_busy, O_frame_done, O_err_timeout;
  logic [4:0] O_level;
  logic [7:0] O_data_out;

  always #5 clk = ~clk;

  spi_tx_feeder #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .I_wr_en(I_wr_en), .I_wr_data(I_wr_data), .I_wr_last(I_wr_last),
    .I_flush(I_flush), .I_clr_err(I_clr_err),
    .O_full(O_full), .O_level(O_level),
    .O_tx_en(O_tx_en), .O_data_out(O_data_out), .I_tx_done(I_tx_done),
    .O_busy(O_busy), .O_frame_done(O_frame_done), .O_err_timeout(O_err_timeout)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Transmitter model: a byte occupies 16 tx_en-high cycles; tx_done pulses in the 16th.
  logic       model_on = 1'b1;
  int         bit_cnt = 0;
  logic [7:0] rx_q[$];
  int         cyc = 0;
  logic       prev_en = 1'b0;
  int         rise_t[$];
  int         fall_t[$];
  int         fd_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    #1;
    cyc++;
    if (!rst_n || !model_on || !O_tx_en) begin
      bit_cnt   = 0;
      I_tx_done = 1'b0;
    end else begin
      bit_cnt++;
      if (bit_cnt == BYTE_CYC) begin
        I_tx_done = 1'b1;
        rx_q.push_back(O_data_out);
        bit_cnt = 0;
      end else begin
        I_tx_done = 1'b0;
      end
    end
    if (O_tx_en && !prev_en) rise_t.push_back(cyc);
    if (!O_tx_en && prev_en) fall_t.push_back(cyc);
    prev_en = O_tx_en;
    if (O_frame_done) fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(input logic [7:0] d, input logic last);
    I_wr_en   = 1'b1;
    I_wr_data = d;
    I_wr_last = last;
    step();
    I_wr_en   = 1'b0;
    I_wr_last = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while ((O_busy || O_level != 0 || O_tx_en) && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(n < budget), 1);
  endtask

  task automatic wait_rise(input int budget, input string tag);
    int n;
    n = 0;
    while (!O_tx_en && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(O_tx_en), 1);
  endtask

  initial begin
    int         rx0, fd0, r0, hi, nfr, len;
    logic [7:0] d;
    logic [7:0] exp_q[$];
    int         lens[$];

    // Reset values
    step(2);
    check("rst_level", O_level, 0);
    check("rst_full", O_full, 0);
    check("rst_tx_en", O_tx_en, 0);
    check("rst_data", O_data_out, 0);
    check("rst_busy", O_busy, 0);
    check("rst_fdone", O_frame_done, 0);
    check("rst_err", O_err_timeout, 0);
    rst_n = 1'b1;
    step(2);

    // Two single-byte frames: 16-cycle bytes separated by exactly GAP low cycles
    rx0 = rx_q.size(); fd0 = fd_cnt; r0 = rise_t.size();
    wr(8'hA5, 1'b1);
    wr(8'h3C, 1'b1);
    wait_idle(200, "t1_idle");
    check("t1_nbytes", rx_q.size() - rx0, 2);
    check("t1_byte0", rx_q[rx0], 8'hA5);
    check("t1_byte1", rx_q[rx0+1], 8'h3C);
    check("t1_fdone", fd_cnt - fd0, 2);
    check("t1_hi0", fall_t[r0] - rise_t[r0], BYTE_CYC);
    check("t1_hi1", fall_t[r0+1] - rise_t[r0+1], BYTE_CYC);
    check("t1_gap", rise_t[r0+1] - fall_t[r0], GAP);

    // Three-byte frame sent back to back under one tx_en run
    rx0 = rx_q.size(); fd0 = fd_cnt; r0 = rise_t.size();
    wr(8'h01, 1'b0);
    wr(8'h02, 1'b0);
    wr(8'h03, 1'b1);
    wait_idle(200, "t2_idle");
    check("t2_runs", rise_t.size() - r0, 1);
    check("t2_hi", fall_t[r0] - rise_t[r0], 3 * BYTE_CYC);
    check("t2_b0", rx_q[rx0], 8'h01);
    check("t2_b1", rx_q[rx0+1], 8'h02);
    check("t2_b2", rx_q[rx0+2], 8'h03);
    check("t2_fdone", fd_cnt - fd0, 1);

    // Watchdog: stalled transmitter times out after TIMEOUT tx_en-high cycles
    model_on = 1'b0;
    wr(8'hB0, 1'b0);
    wait_rise(10, "t4_start");
    hi = 0;
    while (O_tx_en && hi < 100) begin
      hi++;
      step();
    end
    check("t4_hi_cycles", hi, TIMEOUT);
    check("t4_err", O_err_timeout, 1);
    check("t4_tx_en", O_tx_en, 0);
    check("t4_busy_err", O_busy, 1);
    I_clr_err = 1'b1;
    step();
    I_clr_err = 1'b0;
    check("t4_clr_err", O_err_timeout, 0);
    check("t4_clr_idle", O_busy, 0);

    // Clear request coinciding with the timeout cycle: error must stay set
    wr(8'hB1, 1'b0);
    wait_rise(10, "t4b_start");
    step(TIMEOUT - 1);
    I_clr_err = 1'b1;
    step();
    I_clr_err = 1'b0;
    check("t4b_err_kept", O_err_timeout, 1);
    check("t4b_tx_en", O_tx_en, 0);

    // FIFO fills while parked in ERR; the 17th write is dropped
    for (int i = 0; i < DEPTH; i++) wr(8'hC0 + 8'(i), 1'(i == DEPTH - 1));
    check("t3_full", O_full, 1);
    check("t3_level", O_level, DEPTH);
    wr(8'hD0, 1'b1);
    check("t3_level_drop", O_level, DEPTH);
    check("t3_full_drop", O_full, 1);
    rx0 = rx_q.size(); fd0 = fd_cnt; r0 = rise_t.size();
    model_on = 1'b1;
    I_clr_err = 1'b1;
    step();
    I_clr_err = 1'b0;
    check("t3_clr_err", O_err_timeout, 0);
    wait_idle(600, "t3_idle");
    check("t3_nbytes", rx_q.size() - rx0, DEPTH);
    for (int i = 0; i < DEPTH; i++) check("t3_byte", rx_q[rx0+i], 8'hC0 + 8'(i));
    check("t3_fdone", fd_cnt - fd0, 1);
    check("t3_hi", fall_t[r0] - rise_t[r0], DEPTH * BYTE_CYC);

    // Flush mid-byte with 5 queued, alongside a same-cycle write
    rx0 = rx_q.size(); fd0 = fd_cnt;
    for (int i = 0; i < 6; i++) wr(8'h60 + 8'(i), 1'b0);
    step(3);
    check("t5_pre_level", O_level, 5);
    check("t5_pre_tx_en", O_tx_en, 1);
    I_flush = 1'b1; I_wr_en = 1'b1; I_wr_data = 8'hEE;
    step();
    I_flush = 1'b0; I_wr_en = 1'b0;
    check("t5_level", O_level, 0);
    check("t5_tx_en", O_tx_en, 0);
    check("t5_busy", O_busy, 0);
    check("t5_full", O_full, 0);
    step(40);
    check("t5_no_bytes", rx_q.size() - rx0, 0);
    check("t5_no_fdone", fd_cnt - fd0, 0);

    // Underrun: unterminated byte drains to IDLE, frame finishes on a later write
    rx0 = rx_q.size(); fd0 = fd_cnt;
    wr(8'h77, 1'b0);
    wait_idle(100, "t6_idle_a");
    check("t6_byte_a", rx_q[rx0], 8'h77);
    check("t6_no_fdone", fd_cnt - fd0, 0);
    wr(8'h55, 1'b1);
    wait_idle(100, "t6_idle_b");
    check("t6_byte_b", rx_q[rx0+1], 8'h55);
    check("t6_fdone", fd_cnt - fd0, 1);

    // Randomized frame batches checked against frame-level expectations
    for (int it = 0; it < 4; it++) begin
      exp_q.delete();
      lens.delete();
      rx0 = rx_q.size(); fd0 = fd_cnt; r0 = rise_t.size();
      nfr = $urandom_range(1, 4);
      for (int f = 0; f < nfr; f++) begin
        len = $urandom_range(1, 3);
        lens.push_back(len);
        for (int b = 0; b < len; b++) begin
          d = 8'($urandom);
          exp_q.push_back(d);
          wr(d, 1'(b == len - 1));
        end
      end
      wait_idle(1000, "rnd_idle");
      check("rnd_nbytes", rx_q.size() - rx0, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) check("rnd_byte", rx_q[rx0+i], exp_q[i]);
      check("rnd_fdone", fd_cnt - fd0, nfr);
      check("rnd_runs", rise_t.size() - r0, nfr);
      for (int f = 0; f < nfr; f++) begin
        check("rnd_hi", fall_t[r0+f] - rise_t[r0+f], lens[f] * BYTE_CYC);
        if (f > 0) check("rnd_gap", rise_t[r0+f] - fall_t[r0+f-1], GAP);
      end
    end

    // Asynchronous reset mid-byte: outputs clear at once, no completion pulse
    rx0 = rx_q.size(); fd0 = fd_cnt;
    wr(8'h99, 1'b1);
    wr(8'h9A, 1'b1);
    step(8);
    check("ar_pre_tx_en", O_tx_en, 1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_tx_en", O_tx_en, 0);
    check("ar_level", O_level, 0);
    check("ar_busy", O_busy, 0);
    check("ar_data", O_data_out, 0);
    step(3);
    check("ar_no_fdone", fd_cnt - fd0, 0);
    check("ar_no_bytes", rx_q.size() - rx0, 0);
    rst_n = 1'b1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
